// File: rtl/uart_defs.sv
// Shared UART definitions: receiver FSM encoding and the default baud/frame
// constants used by both the transmit and receive paths.
package uart_defs;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_t;

  localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period up-counter with synchronous clear/enable and a terminal-count
// compare against a limit that may change from state to state.
module uart_baud_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = i_en && (r_count == i_limit);

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling FSM, glitch
// rejection on the start bit and framing-error detection on the stop bit.
module uart_rx
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] HALF_LIM = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(CLKS_PER_BIT - 1);

  logic                 r_sync1;
  logic                 r_rxs;
  uart_state_t          r_state;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_err;
  logic                 r_busy;

  logic                 w_en;
  logic                 w_clr;
  logic                 w_tc;
  logic [CNT_W-1:0]     w_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  // The timer only runs in the timed states; every sample point is also a
  // state change or bit boundary, so clearing on terminal count covers both.
  assign w_en    = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_clr   = w_tc || !w_en;
  assign w_limit = (r_state == START) ? HALF_LIM : FULL_LIM;

  uart_baud_counter #(
    .CNT_W(CNT_W)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_limit(w_limit),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rxs) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_tc) begin
            if (!r_rxs) begin
              r_state   <= DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_tc) begin
            r_shift[r_bit_idx] <= r_rxs;
            if (r_bit_idx == LAST_IDX) begin
              r_state   <= STOP;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end
        end
        STOP: begin
          // Returning to IDLE at mid stop bit leaves half a bit of slack
          // for a back-to-back start edge.
          if (w_tc) begin
            if (r_rxs) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_err   <= 1'b1;
              r_state <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (r_rxs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_err;
  assign rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed table,
// hand-written corner sequences and random frames against a frame-level model.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          rx_busy;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .CNT_W       (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap_bits;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  int   cyc            = 0;
  int   valid_cnt      = 0;
  int   err_cnt        = 0;
  int   overlap_cnt    = 0;
  int   long_cnt       = 0;
  int   last_valid_cyc = 0;
  int   busy_low       = 0;
  bit   track_busy     = 1'b0;
  logic prev_v         = 1'b0;
  logic prev_e         = 1'b0;

  always @(posedge clk) cyc++;

  // Frame-level monitor: counts pulses, logs one line per received transaction.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      $display("rx frame %0d data=0x%02h cycle=%0d", valid_cnt, rx_data, cyc);
    end
    if (frame_err === 1'b1) begin
      err_cnt++;
      $display("framing error %0d cycle=%0d", err_cnt, cyc);
    end
    if (rx_valid === 1'b1 && frame_err === 1'b1) overlap_cnt++;
    if ((rx_valid === 1'b1 && prev_v) || (frame_err === 1'b1 && prev_e)) long_cnt++;
    prev_v = (rx_valid === 1'b1);
    prev_e = (frame_err === 1'b1);
    if (track_busy && rx_busy !== 1'b1) busy_low++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic bit_period(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    bit_period(1'b0);
    track_busy = 1'b1;
    for (int i = 0; i < DB; i++) bit_period(d[i]);
    track_busy = 1'b0;
    bit_period(stop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t       vecs[5];
  int         v0, e0, t0, lat, gap;
  logic [7:0] d, exp_last;
  logic       stop;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
    vecs[2] = '{8'h3C, 1'b1, 0, 1, 0, 8'h3C};
    vecs[3] = '{8'h55, 1'b0, 2, 0, 1, 8'h3C};
    vecs[4] = '{8'hC3, 1'b1, 1, 1, 0, 8'hC3};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_rx_busy", int'(rx_busy), 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Single byte with latency measured from the start falling edge.
    v0 = valid_cnt;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    lat = last_valid_cyc - t0;
    check("single_pulses", valid_cnt - v0, 1);
    check("single_data", int'(rx_data), 'hA5);
    check_range("single_latency", lat, 2 + CPB / 2 + 9 * CPB - 1, 2 + CPB / 2 + 9 * CPB + 1);
    check("single_busy_low_cycles", busy_low, 0);
    repeat (CPB) @(negedge clk);
    check("single_busy_after", int'(rx_busy), 0);

    // Directed table: back-to-back frames then a framing error with recovery.
    for (int i = 0; i < 5; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      rx = 1'b1;
      repeat (vecs[i].gap_bits * CPB) @(negedge clk);
      check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_err", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_data", i), int'(rx_data), int'(vecs[i].exp_data));
    end

    // Start glitch shorter than half a bit.
    v0 = valid_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_busy", int'(rx_busy), 0);
    send_frame(8'h81, 1'b1);
    check("glitch_next_valid", valid_cnt - v0, 1);
    check("glitch_next_data", int'(rx_data), 'h81);

    // Framing error followed by a 40-bit break.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("break_err", err_cnt - e0, 1);
    check("break_valid", valid_cnt - v0, 0);
    check("break_data_held", int'(rx_data), 'h81);
    check("break_busy", int'(rx_busy), 1);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("break_busy_after", int'(rx_busy), 0);
    send_frame(8'h12, 1'b1);
    check("break_next_valid", valid_cnt - v0, 1);
    check("break_next_data", int'(rx_data), 'h12);
    check("break_err_total", err_cnt - e0, 1);

    // Reset asserted for one cycle in the middle of data bit 3.
    v0 = valid_cnt;
    e0 = err_cnt;
    bit_period(1'b0);
    bit_period(1'b1);
    bit_period(1'b1);
    bit_period(1'b1);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    check("midrst_rx_data", int'(rx_data), 0);
    check("midrst_rx_valid", int'(rx_valid), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    check("midrst_rx_busy", int'(rx_busy), 0);
    repeat (3 * CPB) @(negedge clk);
    check("midrst_no_valid", valid_cnt - v0, 0);
    check("midrst_no_err", err_cnt - e0, 0);
    check("midrst_idle", int'(rx_busy), 0);
    send_frame(8'h5A, 1'b1);
    check("midrst_next_valid", valid_cnt - v0, 1);
    check("midrst_next_data", int'(rx_data), 'h5A);

    // Random frames: good frames update the held byte, bad ones only pulse frame_err.
    exp_last = 8'h5A;
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      v0   = valid_cnt;
      e0   = err_cnt;
      send_frame(d, stop);
      rx = 1'b1;
      repeat (gap * CPB) @(negedge clk);
      if (stop) exp_last = d;
      check($sformatf("rand%0d_valid", n), valid_cnt - v0, stop ? 1 : 0);
      check($sformatf("rand%0d_err", n), err_cnt - e0, stop ? 0 : 1);
      check($sformatf("rand%0d_data", n), int'(rx_data), int'(exp_last));
    end

    repeat (2 * CPB) @(negedge clk);
    check("final_idle", int'(rx_busy), 0);
    check("valid_err_overlap", overlap_cnt, 0);
    check("pulse_longer_than_one", long_cnt, 0);
    check("busy_low_in_frame", busy_low, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
